// File: rtl/mixer4_sequencer_if.sv
// mixer4_sequencer_if: config write bus and mixed-sample output bus of the mixer.
//   cfg_we/cfg_addr/cfg_gain/cfg_mute : shadow configuration write (master drives)
//   out/out_valid                     : mixed sample and its one-cycle strobe (slave drives)
interface mixer4_sequencer_if #(
    parameter int BITSIZE  = 16,
    parameter int GAINBITS = 8
);
    logic                      cfg_we;
    logic [1:0]                cfg_addr;
    logic [GAINBITS-1:0]       cfg_gain;
    logic                      cfg_mute;
    logic signed [BITSIZE-1:0] out;
    logic                      out_valid;
    modport master (output cfg_we, cfg_addr, cfg_gain, cfg_mute, input out, out_valid);
    modport slave  (input cfg_we, cfg_addr, cfg_gain, cfg_mute, output out, out_valid);
endinterface

// File: rtl/mixer4_sequencer.sv
// mixer4_sequencer: frame-synchronous 4-channel gain/mute mixer sharing one MAC.
//   bclk, reset_n : clock and synchronous active-low reset
//   lrclk         : frame clock; a rising edge starts a frame
//   in1..in4      : signed channel samples, captured at frame start
//   bus           : config writes in, mixed sample and strobe out
//   busy          : frame in progress (through the strobe cycle)
//   overrun       : sticky, a frame edge arrived while busy
module mixer4_sequencer #(
    parameter int BITSIZE  = 16,
    parameter int GAINBITS = 8
) (
    input  logic                      bclk,
    input  logic                      reset_n,
    input  logic                      lrclk,
    input  logic signed [BITSIZE-1:0] in1,
    input  logic signed [BITSIZE-1:0] in2,
    input  logic signed [BITSIZE-1:0] in3,
    input  logic signed [BITSIZE-1:0] in4,
    mixer4_sequencer_if.slave         bus,
    output logic                      busy,
    output logic                      overrun
);
    localparam int AW = BITSIZE + GAINBITS + 3;
    localparam int PW = BITSIZE + GAINBITS + 1;
    localparam logic [GAINBITS-1:0] GDEF = GAINBITS'(1 << (GAINBITS - 2));
    localparam logic signed [AW-1:0] SMAX = {{(GAINBITS + 4){1'b0}}, {(BITSIZE - 1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = ~SMAX;
    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
    state_t state, state_nx;
    logic lr_d, start;
    logic signed [BITSIZE-1:0] smp [4];
    // {mute, gain} per channel
    logic [GAINBITS:0] shadow [4];
    logic [GAINBITS:0] active [4];
    logic signed [AW-1:0] acc, term, shifted;
    logic signed [PW-1:0] prod;
    logic signed [BITSIZE-1:0] sat;
    logic [1:0] idx;
    assign start = lrclk & ~lr_d;
    assign busy  = (state != IDLE) | bus.out_valid;
    always_comb begin
        prod     = PW'(smp[idx]) * PW'($signed({1'b0, active[idx][GAINBITS-1:0]}));
        term     = active[idx][GAINBITS] ? '0 : AW'(prod);
        // arithmetic shift floors the full-precision sum
        shifted  = acc >>> GAINBITS;
        sat      = (shifted > SMAX) ? BITSIZE'(SMAX) :
                   (shifted < SMIN) ? BITSIZE'(SMIN) : shifted[BITSIZE-1:0];
        state_nx = (state == IDLE) ? (start ? MAC : IDLE) :
                   (state == MAC)  ? ((idx == 2'd3) ? OUT : MAC) : IDLE;
    end
    always_ff @(posedge bclk) begin
        if (!reset_n) begin
            state         <= IDLE;
            lr_d          <= 1'b1;
            acc           <= '0;
            idx           <= '0;
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            overrun       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= {1'b0, GDEF};
                active[i] <= {1'b0, GDEF};
                smp[i]    <= '0;
            end
        end else begin
            state         <= state_nx;
            lr_d          <= lrclk;
            bus.out_valid <= (state == OUT);
            if (bus.cfg_we)
                shadow[bus.cfg_addr] <= {bus.cfg_mute, bus.cfg_gain};
            if (start && state != IDLE)
                overrun <= 1'b1;
            // active takes the pre-write shadow; a same-cycle write applies next frame
            if (start && state == IDLE) begin
                smp    <= '{in1, in2, in3, in4};
                active <= shadow;
                acc    <= '0;
                idx    <= '0;
            end
            if (state == MAC) begin
                acc <= acc + term;
                idx <= idx + 2'd1;
            end
            if (state == OUT)
                bus.out <= sat;
        end
    end
endmodule

// File: tb/tb_mixer4_sequencer.sv
// tb_mixer4_sequencer: directed self-checking bench with a per-cycle reference model.
module tb_mixer4_sequencer;
    localparam int GB = 8;
    logic bclk = 1'b0;
    logic reset_n, lrclk;
    logic signed [15:0] in1, in2, in3, in4;
    logic busy, overrun;
    mixer4_sequencer_if #(.BITSIZE(16), .GAINBITS(GB)) bus ();
    mixer4_sequencer #(.BITSIZE(16), .GAINBITS(GB)) dut (
        .bclk(bclk), .reset_n(reset_n), .lrclk(lrclk),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .bus(bus), .busy(busy), .overrun(overrun)
    );
    always #5 bclk = ~bclk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: shadow config, frame countdown, expected outputs
    int m_gain [4];
    bit m_mute [4];
    bit m_lr_d, m_valid, m_ovr;
    int m_cnt, m_out, m_pend;
    wire m_start = lrclk && !m_lr_d;

    function automatic int mix(input int a, input int b, input int c, input int d);
        int s [4];
        longint sum;
        s = '{a, b, c, d};
        sum = 0;
        for (int i = 0; i < 4; i++)
            if (!m_mute[i]) sum += longint'(s[i]) * m_gain[i];
        sum = sum >>> GB;
        if (sum > 32767) sum = 32767;
        if (sum < -32768) sum = -32768;
        return int'(sum);
    endfunction

    always @(posedge bclk) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                m_gain[i] <= 64;
                m_mute[i] <= 1'b0;
            end
            m_lr_d  <= 1'b1;
            m_cnt   <= 0;
            m_out   <= 0;
            m_valid <= 1'b0;
            m_ovr   <= 1'b0;
        end else begin
            m_lr_d  <= lrclk;
            m_valid <= (m_cnt == 1);
            if (m_cnt == 1) m_out <= m_pend;
            if (m_start && m_cnt == 0) begin
                m_pend <= mix(in1, in2, in3, in4);
                m_cnt  <= 5;
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
            end
            if (m_start && m_cnt != 0) m_ovr <= 1'b1;
            if (bus.cfg_we) begin
                m_gain[bus.cfg_addr] <= int'(bus.cfg_gain);
                m_mute[bus.cfg_addr] <= bus.cfg_mute;
            end
        end
    end

    always @(negedge bclk) begin
        if (chk_en) begin
            chk("cyc out", int'(bus.out), m_out);
            chk("cyc out_valid", int'(bus.out_valid), int'(m_valid));
            chk("cyc busy", int'(busy), int'(m_cnt != 0 || m_valid));
            chk("cyc overrun", int'(overrun), int'(m_ovr));
        end
    end

    task automatic step();
        @(posedge bclk);
        #1;
    endtask

    task automatic cfg(input int ch, input int g, input bit m);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 2'(ch);
        bus.cfg_gain = 8'(g);
        bus.cfg_mute = m;
        step();
        bus.cfg_we = 1'b0;
    endtask

    // One frame; optional gain0 = 0 write on the frame-start cycle
    task automatic frame(input int a, input int b, input int c, input int d,
                         input int exp, input bit we, input string name);
        int k;
        in1 = 16'(a); in2 = 16'(b); in3 = 16'(c); in4 = 16'(d);
        lrclk = 1'b1;
        if (we) begin
            bus.cfg_we = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_gain = 8'd0; bus.cfg_mute = 1'b0;
        end
        step();
        lrclk = 1'b0;
        bus.cfg_we = 1'b0;
        k = 0;
        while (k < 20) begin
            @(negedge bclk);
            k++;
            if (bus.out_valid) break;
        end
        chk({name, " latency"}, k, 6);
        chk({name, " out"}, int'(bus.out), exp);
        step();
        step();
    endtask

    initial begin
        int nv, v;
        reset_n = 1'b0; lrclk = 1'b1;
        in1 = 0; in2 = 0; in3 = 0; in4 = 0;
        bus.cfg_we = 1'b0; bus.cfg_addr = 2'd0; bus.cfg_gain = 8'd0; bus.cfg_mute = 1'b0;
        repeat (3) step();
        chk_en = 1'b1;
        @(negedge bclk);
        chk("reset out", int'(bus.out), 0);
        chk("reset out_valid", int'(bus.out_valid), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset overrun", int'(overrun), 0);
        step();
        reset_n = 1'b1;
        nv = 0;
        repeat (8) begin @(negedge bclk); if (bus.out_valid) nv++; end
        chk("lrclk high at release no frame", nv, 0);
        step();
        lrclk = 1'b0;
        step();

        frame(4000, -800, 1200, 400, 1200, 1'b0, "defaults");
        chk("defaults busy after", int'(busy), 0);

        cfg(0, 128, 1'b0); cfg(1, 64, 1'b1); cfg(2, 64, 1'b1); cfg(3, 64, 1'b1);
        frame(-3, 1000, 1000, 1000, -2, 1'b0, "floor neg");
        frame(3, -500, 7, 9, 1, 1'b0, "floor pos");

        for (int i = 0; i < 4; i++) cfg(i, 255, 1'b0);
        frame(32767, 32767, 32767, 32767, 32767, 1'b0, "sat pos");
        frame(-32768, -32768, -32768, -32768, -32768, 1'b0, "sat neg");

        for (int i = 0; i < 4; i++) cfg(i, 64, 1'b0);
        frame(400, 0, 0, 0, 100, 1'b1, "shadow same cycle");
        frame(400, 0, 0, 0, 0, 1'b0, "shadow next frame");
        cfg(0, 64, 1'b0);

        chk("overrun before", int'(overrun), 0);
        in1 = 1000; in2 = 1000; in3 = 1000; in4 = 1000;
        lrclk = 1'b1;
        step();
        lrclk = 1'b0;
        in1 = 0; in2 = 0; in3 = 0; in4 = 0;
        step();
        step();
        lrclk = 1'b1;
        step();
        lrclk = 1'b0;
        nv = 0; v = 0;
        repeat (15) begin
            @(negedge bclk);
            if (bus.out_valid) begin nv++; v = int'(bus.out); end
        end
        chk("overrun strobes", nv, 1);
        chk("overrun out", v, 1000);
        chk("overrun flag", int'(overrun), 1);
        step();

        cfg(0, 200, 1'b0);
        in1 = 1000; in2 = 0; in3 = 0; in4 = 0;
        lrclk = 1'b1;
        step();
        lrclk = 1'b0;
        step();
        reset_n = 1'b0;
        lrclk = 1'b1;
        step();
        @(negedge bclk);
        chk("midreset out", int'(bus.out), 0);
        chk("midreset busy", int'(busy), 0);
        chk("midreset overrun", int'(overrun), 0);
        step();
        reset_n = 1'b1;
        nv = 0;
        repeat (12) begin @(negedge bclk); if (bus.out_valid) nv++; end
        chk("midreset no strobe", nv, 0);
        step();
        lrclk = 1'b0;
        step();
        frame(400, 0, 0, 0, 100, 1'b0, "post reset gain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mixer4_sequencer.md
# mixer4_sequencer

Frame-synchronous controller for the four-channel audio mixer. On each rising edge of `lrclk` it captures the four inputs and runs them one per cycle through a single shared multiply-accumulate, using programmable per-channel gain and mute. It then saturates the sum and presents one mixed sample with a valid strobe. It sits between the channel sources and the I2S transmitter, replacing the fixed 0.25 mix with a runtime-configurable one. Everything runs in the `bclk` domain.

## Interface

- Parameters:
  - `BITSIZE`, 16, sample width (signed).
  - `GAINBITS`, 8, gain width; unsigned gain in units of 1/2^GAINBITS.
- Ports (single clock `bclk`; reset is synchronous and active-low):
  - `bclk` input, 1: system clock, 64x `lrclk`.
  - `reset_n` input, 1: synchronous, active-low reset, sampled on `bclk` rising edge.
  - `lrclk` input, 1: frame clock, generated synchronously to `bclk`.
  - `in1`..`in4` input, BITSIZE each: signed channel samples.
  - `cfg_we` input, 1: write strobe for the shadow configuration.
  - `cfg_addr` input, 2: channel select, 0 = `in1` .. 3 = `in4`.
  - `cfg_gain` input, GAINBITS: unsigned gain to write.
  - `cfg_mute` input, 1: mute bit to write.
  - `out` output, BITSIZE: signed mixed sample, registered.
  - `out_valid` output, 1: one-cycle strobe when `out` updates.
  - `busy` output, 1: high while a frame is being computed.
  - `overrun` output, 1: sticky; set when an `lrclk` edge is dropped.

## Operation

- **Frame detect.**
  - Register `lr_d` holds `lrclk` from the previous cycle.
  - A frame starts when `lrclk & ~lr_d`.
  - `lr_d` resets to 1, so `lrclk` held high through reset release never starts a spurious frame.
- **States and transitions.**
  - IDLE, frame start: latch `in1`..`in4` into sample registers, copy shadow config to active config, clear `acc`, set `idx` = 0. Next state MAC.
  - MAC: `acc += sample[idx] * gain[idx]`, or add 0 if `mute[idx]`. Increment `idx`. After `idx` = 3, next state OUT.
  - OUT: `out <= sat(acc >>> GAINBITS)`, `out_valid` = 1. Next state IDLE.
- **Arithmetic.**
  - Gain is zero-extended before the signed multiply.
  - `acc` is BITSIZE+GAINBITS+3 bits wide, so it never wraps.
  - Shift is arithmetic, giving a floor of the full sum, not a sum of floors.
  - Saturate to [-2^(BITSIZE-1), 2^(BITSIZE-1)-1].
- **Configuration.**
  - When `cfg_we` = 1: `shadow[cfg_addr] <= {cfg_mute, cfg_gain}`. Writes are legal in any state.
  - Active config changes only at frame start.
  - A write on the same cycle as frame start lands in shadow. The frame uses the pre-write shadow value; the new value applies from the next frame.
- **Overrun.** A frame-start edge while `busy` is ignored (no capture, no restart) and sets `overrun`. Only reset clears `overrun`.
- **Reset values.**
  - Outputs: `out` = 0, `out_valid` = 0, `busy` = 0, `overrun` = 0.
  - Internal: state IDLE, `acc` = 0, `idx` = 0.
  - Configuration: all shadow and active gains = 2^(GAINBITS-2) (64, i.e. 0.25), all unmuted.
  - Reset asserted mid-frame aborts the frame; no `out_valid` is produced for it.

## Timing

- Let T0 be the `bclk` edge that sees the frame start in IDLE; the capture happens at T0.
- T1..T4: MAC for channels 0..3.
- T5: `out` and `out_valid` are registered. `out_valid` is high for exactly the cycle after T5, then low.
- Latency from capture to valid is 5 cycles. `busy` is high from after T0 through the cycle after T5.
- Minimum frame spacing is 6 `bclk` cycles; at 64 `bclk` per frame an overrun never occurs in normal use.
- `out` holds its value between strobes.

## Test plan

- **Reset defaults:** `in1`..`in4` = 4000, -800, 1200, 400, one `lrclk` edge -> `out` = 1200, `out_valid` high for one cycle 5 cycles after capture, `busy` low afterwards.
- **Saturation:**
  - All gains 255, all inputs 32767 -> `out` = 32767.
  - All inputs -32768 -> `out` = -32768.
- **Floor rounding:** mute channels 1-3, gain0 = 128, `in1` = -3 -> `out` = -2. With `in1` = 3 -> `out` = 1.
- **Shadow timing:** at defaults, write gain0 = 0 on the frame-start cycle with `in1` = 400, others 0 -> that frame `out` = 100; next frame `out` = 0.
- **Overrun:** a second `lrclk` rising edge 3 cycles after capture -> `overrun` = 1, the first frame's `out` is correct, exactly one `out_valid`.
- **Reset mid-frame:** `reset_n` low during MAC (T2) -> next cycle `out` = 0, `busy` = 0, gains back to 64, no strobe. Release reset with `lrclk` high -> no frame until the next rising edge.
